// File: rtl/lpgbt_capture_pkg.sv
// Shared types and register map for the lpGBT uplink capture engine.
package lpgbt_capture_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_e;

  localparam int REG_CONTROL = 0;
  localparam int REG_STATUS  = 1;
  localparam int REG_LENGTH  = 2;
  localparam int REG_DATA    = 3;

  localparam int CTL_ARM     = 0;
  localparam int CTL_ABORT   = 1;
  localparam int CTL_CONT    = 2;
  localparam int CTL_SEL_LSB = 4;
  localparam int CTL_RST_LSB = 8;
  localparam int CTL_POL_LSB = 16;

  localparam int STS_WRAPPED = 2;
  localparam int STS_LOST    = 3;
  localparam int STS_UNDER   = 4;
  localparam int STS_RDY_LSB = 8;
  localparam int STS_CNT_LSB = 16;

  function automatic int words(input int bits);
    return (bits + 31) / 32;
  endfunction
endpackage

// File: rtl/lpgbt_capture_buf.sv
// Simple dual-port frame buffer, registered read, no reset so it maps onto block RAM.
module lpgbt_capture_buf #(
  parameter int DEPTH = 64,
  parameter int W     = 234,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          gclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge gclk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/lpgbt_uplink_capture.sv
// Multi-channel lpGBT uplink frame capture with register-bank readout.
// Define LPGBT_CAPTURE_TIMESTAMP_EN to store a 32-bit cycle stamp with each frame.
module lpgbt_uplink_capture
  import lpgbt_capture_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int N_CH               = 2,
  parameter int FRAME_W            = 234,
  parameter int DEPTH              = 64,
  parameter int REG_N              = 4
) (
  input  logic                                         S_AXI_ACLK,
  input  logic                                         S_AXI_ARESETN,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                reg_wrdout,
  input  logic [REG_N-1:0][3:0]                        reg_wrByteStrobe,
  input  logic [REG_N-1:0]                             reg_rdStrobe,
  output logic [REG_N-1:0][C_S_AXI_DATA_WIDTH-1:0]     reg_rddin,
  input  logic [N_CH*FRAME_W-1:0]                      uplink_data_i,
  input  logic [N_CH-1:0]                              uplink_valid_i,
  input  logic [N_CH-1:0]                              uplink_rdy_i,
  output logic [N_CH-1:0]                              uplink_rst_o,
  output logic [N_CH-1:0]                              rx_polarity_o,
  output logic                                         irq_o
);
`ifdef LPGBT_CAPTURE_TIMESTAMP_EN
  localparam int TS_W = 32;
`else
  localparam int TS_W = 0;
`endif
  localparam int RW  = FRAME_W + TS_W;
  localparam int WPF = words(RW);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WW  = $clog2(WPF + 1);

  cap_state_e      state_q, state_d;
  logic            cont_q, cont_d;
  logic [2:0]      sel_q, sel_d;
  logic [N_CH-1:0] urst_q, urst_d, pol_q, pol_d;
  logic [15:0]     len_q, len_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d, rd_frame_q, rd_frame_d, len_eff;
  logic            wrapped_q, wrapped_d, lost_q, lost_d, under_q, under_d;
  logic [WW-1:0]   rd_word_q, rd_word_d;

  logic               wr_ctl, wr_len, arm, abort, rd_data, we, clear, rd_avail;
  logic               sel_rdy, sel_vld;
  logic [FRAME_W-1:0] sel_frame;
  logic [RW-1:0]      ram_wdata, ram_rdata;
  logic [AW-1:0]      base, raddr;
  logic [WPF*32-1:0]  rd_pad;
  logic [31:0]        data_word;
  logic               unused_in;

  assign unused_in = ^{reg_wrdout, reg_wrByteStrobe, reg_rdStrobe};

  assign wr_ctl  = |reg_wrByteStrobe[REG_CONTROL];
  assign wr_len  = |reg_wrByteStrobe[REG_LENGTH];
  assign abort   = wr_ctl & reg_wrdout[CTL_ABORT];
  assign arm     = wr_ctl & reg_wrdout[CTL_ARM] & ~reg_wrdout[CTL_ABORT];
  assign rd_data = reg_rdStrobe[REG_DATA];

  always_comb begin
    sel_rdy   = 1'b0;
    sel_vld   = 1'b0;
    sel_frame = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (sel_q == 3'(c)) begin
        sel_rdy   = uplink_rdy_i[c];
        sel_vld   = uplink_valid_i[c];
        sel_frame = uplink_data_i[c*FRAME_W +: FRAME_W];
      end
    end
  end

  always_comb begin
    if (len_q == '0 || 32'(len_q) > DEPTH) len_eff = CW'(DEPTH);
    else                                   len_eff = CW'(len_q);
  end

`ifdef LPGBT_CAPTURE_TIMESTAMP_EN
  logic [31:0] ts_q;
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) ts_q <= '0;
    else                ts_q <= ts_q + 32'd1;
  end
  // Stamp in the low word so it is emitted ahead of the frame words.
  assign ram_wdata = {sel_frame, ts_q};
`else
  assign ram_wdata = sel_frame;
`endif

  always_comb begin
    state_d    = state_q;
    cont_d     = cont_q;
    sel_d      = sel_q;
    urst_d     = urst_q;
    pol_d      = pol_q;
    len_d      = len_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    wrapped_d  = wrapped_q;
    lost_d     = lost_q;
    under_d    = under_q;
    rd_frame_d = rd_frame_q;
    rd_word_d  = rd_word_q;
    we         = 1'b0;
    clear      = 1'b0;

    if (wr_ctl) begin
      cont_d = reg_wrdout[CTL_CONT];
      if (32'(reg_wrdout[CTL_SEL_LSB +: 3]) < N_CH) sel_d = reg_wrdout[CTL_SEL_LSB +: 3];
      urst_d = reg_wrdout[CTL_RST_LSB +: N_CH];
      pol_d  = reg_wrdout[CTL_POL_LSB +: N_CH];
    end
    if (wr_len) len_d = reg_wrdout[15:0];

    case (state_q)
      ST_IDLE: if (arm) begin state_d = ST_ARMED; clear = 1'b1; end
      ST_ARMED: begin
        if (abort) state_d = ST_IDLE;
        else if (sel_rdy) begin state_d = ST_CAPTURE; we = sel_vld; end
      end
      ST_CAPTURE: begin
        if (abort) state_d = ST_DONE;
        else if (!sel_rdy) begin state_d = ST_DONE; lost_d = 1'b1; end
        else we = sel_vld;
      end
      default: begin
        if (abort) state_d = ST_IDLE;
        else if (arm) begin state_d = ST_ARMED; clear = 1'b1; end
      end
    endcase

    if (we) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + 1'b1;
      if (cont_q && wr_ptr_q == AW'(DEPTH - 1)) wrapped_d = 1'b1;
      if (!cont_q && cnt_d >= len_eff) state_d = ST_DONE;
    end

    if (rd_data) begin
      if (rd_avail) begin
        if (rd_word_q == WW'(WPF - 1)) begin
          rd_word_d  = '0;
          rd_frame_d = rd_frame_q + 1'b1;
        end else begin
          rd_word_d = rd_word_q + 1'b1;
        end
      end else begin
        under_d = 1'b1;
      end
    end

    if (clear) begin
      wr_ptr_d   = '0;
      cnt_d      = '0;
      wrapped_d  = 1'b0;
      lost_d     = 1'b0;
      under_d    = 1'b0;
      rd_frame_d = '0;
      rd_word_d  = '0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= ST_IDLE;
      cont_q     <= 1'b0;
      sel_q      <= '0;
      urst_q     <= '0;
      pol_q      <= '0;
      len_q      <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      wrapped_q  <= 1'b0;
      lost_q     <= 1'b0;
      under_q    <= 1'b0;
      rd_frame_q <= '0;
      rd_word_q  <= '0;
    end else begin
      state_q    <= state_d;
      cont_q     <= cont_d;
      sel_q      <= sel_d;
      urst_q     <= urst_d;
      pol_q      <= pol_d;
      len_q      <= len_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      wrapped_q  <= wrapped_d;
      lost_q     <= lost_d;
      under_q    <= under_d;
      rd_frame_q <= rd_frame_d;
      rd_word_q  <= rd_word_d;
    end
  end

  // Once wrapped the oldest surviving frame sits at the write pointer.
  assign base     = wrapped_q ? wr_ptr_q : '0;
  assign raddr    = base + rd_frame_q[AW-1:0];
  assign rd_avail = (state_q == ST_DONE) && (rd_frame_q < cnt_q);

  lpgbt_capture_buf #(.DEPTH(DEPTH), .W(RW), .AW(AW)) u_buf (
    .gclk  (S_AXI_ACLK),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (ram_wdata),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    rd_pad             = '0;
    rd_pad[RW-1:0]     = ram_rdata;
    data_word          = rd_avail ? rd_pad[int'(rd_word_q)*32 +: 32] : '0;
  end

  always_comb begin
    reg_rddin = '0;
    reg_rddin[REG_CONTROL][CTL_CONT]              = cont_q;
    reg_rddin[REG_CONTROL][CTL_SEL_LSB +: 3]      = sel_q;
    reg_rddin[REG_CONTROL][CTL_RST_LSB +: N_CH]   = urst_q;
    reg_rddin[REG_CONTROL][CTL_POL_LSB +: N_CH]   = pol_q;
    reg_rddin[REG_STATUS][1:0]                    = state_q;
    reg_rddin[REG_STATUS][STS_WRAPPED]            = wrapped_q;
    reg_rddin[REG_STATUS][STS_LOST]               = lost_q;
    reg_rddin[REG_STATUS][STS_UNDER]              = under_q;
    reg_rddin[REG_STATUS][STS_RDY_LSB +: N_CH]    = uplink_rdy_i;
    reg_rddin[REG_STATUS][STS_CNT_LSB +: 16]      = 16'(cnt_q);
    reg_rddin[REG_LENGTH][15:0]                   = len_q;
    reg_rddin[REG_DATA]                           = data_word;
  end

  assign uplink_rst_o  = urst_q;
  assign rx_polarity_o = pol_q;
  assign irq_o         = (state_q == ST_DONE);
endmodule

// File: tb/tb_lpgbt_uplink_capture.sv
// Directed bench for lpgbt_uplink_capture: register access, capture modes, readout, async reset.
module tb_lpgbt_uplink_capture;
  localparam int N_CH = 2, FRAME_W = 234, DEPTH = 64;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [31:0]               wdat;
  logic [3:0][3:0]           wstb;
  logic [3:0]                rstb;
  logic [3:0][31:0]          rddin;
  logic [N_CH*FRAME_W-1:0]   udata;
  logic [N_CH-1:0]           vld, rdy, urst, pol;
  logic                      irq;

  int nvec = 0, nerr = 0;
  logic [31:0] last_ts;

  lpgbt_uplink_capture #(.C_S_AXI_DATA_WIDTH(32), .N_CH(N_CH), .FRAME_W(FRAME_W),
                         .DEPTH(DEPTH), .REG_N(4)) dut (
    .S_AXI_ACLK       (clk),
    .S_AXI_ARESETN    (rst_n),
    .reg_wrdout       (wdat),
    .reg_wrByteStrobe (wstb),
    .reg_rdStrobe     (rstb),
    .reg_rddin        (rddin),
    .uplink_data_i    (udata),
    .uplink_valid_i   (vld),
    .uplink_rdy_i     (rdy),
    .uplink_rst_o     (urst),
    .rx_polarity_o    (pol),
    .irq_o            (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic logic [FRAME_W-1:0] frame_of(input int n);
    logic [255:0] p;
    for (int k = 0; k < 8; k++) p[k*32 +: 32] = {8'(n), 8'(k), ~8'(n), 8'(k) ^ 8'h5A};
    return p[FRAME_W-1:0];
  endfunction

  function automatic logic [31:0] exp_word(input int n, input int k);
    logic [255:0] p;
    p = '0;
    p[FRAME_W-1:0] = frame_of(n);
    return p[k*32 +: 32];
  endfunction

  task automatic reg_wr(input int r, input logic [31:0] d);
    @(negedge clk); wdat = d; wstb[r] = 4'hF;
    @(negedge clk); wstb = '0;
  endtask

  task automatic reg_rd(input int r, output logic [31:0] d);
    @(negedge clk); d = rddin[r]; rstb[r] = 1'b1;
    @(negedge clk); rstb = '0;
    repeat (2) @(negedge clk);
  endtask

  // Channel 1 carries frame n; channel 0 carries a decoy that must never be stored.
  task automatic send(input int n);
    @(negedge clk);
    udata[FRAME_W +: FRAME_W] = frame_of(n);
    udata[0 +: FRAME_W]       = frame_of(200);
    vld = 2'b11;
    @(negedge clk); vld = '0;
  endtask

  task automatic rd_frame(input int n);
    logic [31:0] d;
`ifdef LPGBT_CAPTURE_TIMESTAMP_EN
    reg_rd(3, d);
    chk($sformatf("ts_inc_f%0d", n), 32'(d > last_ts), 32'd1);
    last_ts = d;
`endif
    for (int k = 0; k < 8; k++) begin
      reg_rd(3, d);
      chk($sformatf("data_f%0d_w%0d", n, k), d, exp_word(n, k));
    end
  endtask

  initial begin
    logic [31:0] d;
    rst_n = 1'b0; wdat = '0; wstb = '0; rstb = '0; udata = '0; vld = '0; rdy = '0;
    last_ts = '0;
    #12;
    chk("rst_urst", 32'(urst), 0);
    chk("rst_pol", 32'(pol), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_status", rddin[1], 0);
    chk("rst_data", rddin[3], 0);
    @(negedge clk); rst_n = 1'b1;

    // Control outputs
    reg_wr(0, 32'h0000_0302);
    chk("ctl_urst", 32'(urst), 32'h3);
    chk("ctl_pol", 32'(pol), 0);
    chk("ctl_readback", rddin[0], 32'h0000_0300);

    // Single-shot capture of 4 frames on channel 1
    reg_wr(2, 32'd4);
    chk("len_readback", rddin[2], 32'd4);
    reg_wr(0, 32'h0000_0011);
    repeat (10) @(negedge clk);
    chk("armed_wait", rddin[1], 32'h0000_0001);
    udata[FRAME_W +: FRAME_W] = frame_of(0);
    udata[0 +: FRAME_W]       = frame_of(200);
    rdy = 2'b10; vld = 2'b11;
    @(negedge clk); vld = '0;
    for (int n = 1; n < 4; n++) send(n);
    chk("done_irq", 32'(irq), 1);
    chk("done_status", rddin[1], 32'h0004_0203);
    repeat (3) @(negedge clk);
    for (int n = 0; n < 4; n++) rd_frame(n);
    reg_rd(3, d);
    chk("past_end_data", d, 0);
    chk("past_end_status", rddin[1], 32'h0004_0213);

    // Continuous ring capture with wrap
    reg_wr(0, 32'h0000_0015);
    last_ts = '0;
    for (int n = 0; n < 70; n++) send(n);
    chk("cont_still_capt", rddin[1] & 32'h3, 32'd2);
    reg_wr(0, 32'h0000_0016);
    chk("wrap_status", rddin[1], 32'h0040_0207);
    repeat (3) @(negedge clk);
    rd_frame(6);
    rd_frame(7);

    // Link lost with a valid frame in the same cycle
    reg_wr(0, 32'h0000_0011);
    last_ts = '0;
    send(0);
    send(1);
    @(negedge clk);
    udata[FRAME_W +: FRAME_W] = frame_of(50);
    rdy = 2'b00; vld = 2'b10;
    @(negedge clk); vld = '0;
    chk("lost_status", rddin[1], 32'h0002_000B);
    chk("lost_irq", 32'(irq), 1);
    repeat (3) @(negedge clk);
    rd_frame(0);
    rd_frame(1);
    reg_rd(3, d);
    chk("lost_discard", d, 0);

    // Command corner cases
    reg_wr(0, 32'h0000_0012);
    chk("abort_to_idle", rddin[1] & 32'h3, 0);
    rdy = 2'b10;
    reg_wr(0, 32'h0000_0011);
    send(10);
    reg_wr(0, 32'h0000_0011);
    chk("arm_in_capt", rddin[1], 32'h0001_0202);
    reg_wr(0, 32'h0000_0012);
    chk("abort_capt", rddin[1], 32'h0001_0203);
    reg_wr(0, 32'h0000_0012);
    rdy = 2'b00;
    reg_wr(0, 32'h0000_0011);
    chk("rearm", rddin[1] & 32'h3, 1);
    reg_wr(0, 32'h0000_0013);
    chk("arm_abort", rddin[1] & 32'h3, 0);
    reg_wr(0, 32'h0000_0051);
    chk("sel_keep", rddin[0], 32'h0000_0010);
    rdy = 2'b01;
    repeat (3) @(negedge clk);
    chk("sel_other_rdy", rddin[1] & 32'h3, 1);
    reg_rd(3, d);
    chk("rd_not_done", d, 0);
    chk("under_armed", rddin[1], 32'h0000_0111);

    // Asynchronous reset mid-capture
    rdy = 2'b10;
    reg_wr(0, 32'h0001_0311);
    send(20);
    chk("pre_rst_state", rddin[1] & 32'h3, 2);
    chk("pre_rst_urst", 32'(urst), 32'h3);
    chk("pre_rst_pol", 32'(pol), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b0; rdy = '0;
    #1;
    chk("arst_urst", 32'(urst), 0);
    chk("arst_pol", 32'(pol), 0);
    chk("arst_status", rddin[1], 0);
    chk("arst_ctl", rddin[0], 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_irq", 32'(irq), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/lpgbt_uplink_capture.md
Name: lpgbt_uplink_capture

Overview:
Parametrised multi-channel lpGBT uplink frame capture engine. Arms on software command, waits for the selected link to be ready, stores uplink user frames into an on-chip buffer, then returns them word-by-word through the existing register-bank interface. It also drives per-channel uplink reset and RX polarity controls. It sits beside axi4lite_interface_top and takes frames already synchronised into the S_AXI_ACLK domain.

Parameters:
C_S_AXI_DATA_WIDTH, 32, register data width (fixed 32 in this block)
N_CH, 2, uplink channel count, 1..8
FRAME_W, 234, uplink user frame width in bits
DEPTH, 64, buffer depth in frames, power of two, 2..4096
REG_N, 4, register count presented to the register bank (fixed)

Ports:
S_AXI_ACLK  in  1  sole clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
reg_wrdout  in  32  register write data
reg_wrByteStrobe  in  REG_N x 4  per-register byte write strobes
reg_rdStrobe  in  REG_N x 1  per-register read strobes
reg_rddin  out  REG_N x 32  per-register read data
uplink_data_i  in  N_CH*FRAME_W  channel c occupies bits [c*FRAME_W +: FRAME_W]
uplink_valid_i  in  N_CH  one-cycle frame-valid per channel
uplink_rdy_i  in  N_CH  link-ready per channel
uplink_rst_o  out  N_CH  uplink reset per channel
rx_polarity_o  out  N_CH  MGT RX polarity per channel
irq_o  out  1  capture-complete level

Behaviour:
- Clock and reset: one clock, S_AXI_ACLK. Reset is asynchronous and active-low on S_AXI_ARESETN.
- Reset values: all outputs 0, state IDLE, pointers and counts 0, sticky flags 0. Buffer contents are undefined.
- Register writes: a register is written when any of its byte strobes is nonzero; the whole 32-bit word is taken.
- Reg 0, CONTROL:
  - [0] ARM: pulse, reads 0.
  - [1] ABORT: pulse, reads 0.
  - [2] CONT: continuous/ring mode.
  - [6:4] CH_SEL: a write with CH_SEL >= N_CH keeps the previous CH_SEL; the other fields still update.
  - [8+:N_CH] drive uplink_rst_o. [16+:N_CH] drive rx_polarity_o.
  - Outputs are registered and change 1 cycle after the write.
- Reg 1, STATUS (read-only):
  - [1:0] state: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
  - [2] wrapped, [3] link_lost, [4] underflow.
  - [15:8] uplink_rdy_i, zero-extended.
  - [31:16] frames stored.
- Reg 2, LENGTH: [15:0] target frame count, read back as written. A value of 0 or >DEPTH means DEPTH.
- Reg 3, DATA: current readout word. Each reg_rdStrobe[3] advances the readout to the next word.
- FSM transitions:
  - IDLE + ARM -> ARMED. ARM clears pointers, count and sticky flags.
  - ARMED + uplink_rdy_i[sel] -> CAPTURE; the first frame is eligible in the same cycle.
  - ARMED + ABORT -> IDLE.
  - CAPTURE: each uplink_valid_i[sel] writes the frame at wr_ptr and increments wr_ptr mod DEPTH.
  - CAPTURE, non-CONT: go to DONE once the count reaches LENGTH.
  - CAPTURE, CONT: writes wrap; the first wrap sets wrapped; the count saturates at DEPTH; only ABORT goes to DONE.
  - CAPTURE + ABORT -> DONE with the frames held so far.
  - CAPTURE + uplink_rdy_i[sel] low -> DONE, link_lost=1. A valid frame in that same cycle is discarded.
  - DONE + ARM -> ARMED (previous data discarded). DONE + ABORT -> IDLE.
  - ARM in ARMED or CAPTURE is ignored. ARM and ABORT in the same write: ABORT wins.
- irq_o: 1 exactly while the state is DONE.
- Readout ordering:
  - Readout is only active in DONE. WORDS = ceil(FRAME_W/32). Word k is frame bits [32k+31:32k], with the top word zero-padded.
  - Frames come out oldest first. When wrapped, the oldest frame is at wr_ptr.
  - After the final word of the final frame, reads return 0 and set underflow.
  - DATA reads in any state other than DONE return 0, set underflow and move nothing.
- Readout timing:
  - The buffer uses a registered (synchronous) read with one-word prefetch.
  - reg_rddin[3] is valid no later than 3 cycles after entering DONE or after the previous strobe. The register bank's read spacing of at least 3 cycles guarantees this.
- Reset mid-capture: an immediate return to the reset state; no partial flags survive.

Optional Feature:
LPGBT_CAPTURE_TIMESTAMP_EN
- Defined:
  - A 32-bit free-running cycle counter, cleared by reset, runs continuously.
  - Each stored frame carries the counter value at its write cycle.
  - Readout emits WORDS+1 words per frame, timestamp first.
- Undefined: no counter and no timestamp storage; WORDS words per frame.

Decomposition:
- Package lpgbt_capture_pkg holds:
  - the state enum (IDLE/ARMED/CAPTURE/DONE);
  - register index constants REG_CONTROL=0, REG_STATUS=1, REG_LENGTH=2, REG_DATA=3;
  - CONTROL/STATUS bit-position constants;
  - a WORDS computation function.
- One sub-module, lpgbt_capture_buf: simple dual-port RAM, DEPTH x (FRAME_W [+32]), registered read, inferable as BRAM.

Test Plan:
1. Reset -> all outputs 0 and STATUS=0. Write CONTROL=0x0000_0302 with N_CH=2 -> uplink_rst_o=2'b11, rx_polarity_o=0, 1 cycle later.
2. LENGTH=4, CH_SEL=1, ARM. Hold rdy[1]=0 for 10 cycles -> STATUS.state=1. Raise rdy[1] and send 4 frames with frame n = n replicated -> DONE, irq_o=1, count=4. 32 DATA reads return frame0 word0..7 through frame3, with word7 = bits [233:224] zero-padded. The 33rd read returns 0 and sets underflow=1.
3. CONT=1, DEPTH=64, send 70 frames, then ABORT -> DONE, wrapped=1, count=64. The first frame read out is frame 6.
4. In CAPTURE after 2 frames, drop rdy[sel] in the same cycle as a valid frame -> DONE, link_lost=1, count=2.
5. ARM during CAPTURE -> ignored. ARM+ABORT written together in ARMED -> IDLE. Write CH_SEL=5 with N_CH=2 -> CH_SEL unchanged.
6. Assert S_AXI_ARESETN low mid-capture, asynchronously between clock edges -> outputs 0 immediately. With LPGBT_CAPTURE_TIMESTAMP_EN defined, timestamps are strictly increasing and 9 words are read per frame.
